// File: rtl/seg7_pkg.sv
// Shared constants for the frequency display path: 7-segment patterns
// (active-low, bit order {g,f,e,d,c,b,a}) and the display FSM state encoding.
package seg7_pkg;

  // All segments off.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  // Only segment g lit; shown on every digit when the value is over-range.
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Decimal digit patterns, indexed by the BCD value.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  // Display FSM states.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;

endpackage

// File: rtl/seg7_encoder.sv
// Combinational BCD digit to active-low 7-segment pattern.
// i_blank forces all segments off; a nibble above 9 also shows blank.
import seg7_pkg::*;

module seg7_encoder (
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  // Table lookup for valid digits, blank for everything else.
  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank && (i_bcd <= 4'd9)) begin
      o_seg = SEG_DIGIT[i_bcd];
    end
  end

endmodule

// File: rtl/freq_display_driver.sv
// Display stage for the frequency detector. A captured binary value is
// converted to three BCD digits with an iterative shift-add-3 (double
// dabble), then the HEX2/HEX1/HEX0 patterns are registered in one step so
// the displays never show intermediate conversion results. One pending
// entry absorbs strobes that arrive while a conversion is in flight; a
// newer strobe overwrites it, and a strobe seen in IDLE beats it.
import seg7_pkg::*;

module freq_display_driver #(
  parameter int          IN_W          = 10,
  parameter int unsigned MAX_VAL       = 999,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic            MAX10_CLK1_50,
  input  logic            reset,
  input  logic [IN_W-1:0] value_in,
  input  logic            value_valid,
  output logic [6:0]      HEX0,
  output logic [6:0]      HEX1,
  output logic [6:0]      HEX2,
  output logic            busy,
  output logic            overflow
);

  // Handshake: value_valid is a one-cycle strobe with no ready; value_in is
  // sampled on every edge where value_valid is high, and the block never
  // back-pressures (busy is informational only).

  localparam int SH_W  = 12 + IN_W;
  localparam int CNT_W = $clog2(IN_W + 1);

  logic [1:0]      r_state;
  logic [SH_W-1:0] r_sh;
  logic [IN_W-1:0] r_bin;
  logic [CNT_W-1:0] r_cnt;
  logic            r_pend_valid;
  logic [IN_W-1:0] r_pend_val;
  logic [6:0]      r_hex0;
  logic [6:0]      r_hex1;
  logic [6:0]      r_hex2;
  logic            r_ovf;

  logic [SH_W-1:0] w_adj;
  logic [11:0]     w_bcd;
  logic            w_over;
  logic            w_blank2;
  logic            w_blank1;
  logic [6:0]      w_seg0;
  logic [6:0]      w_seg1;
  logic [6:0]      w_seg2;

  // Add 3 to every BCD nibble that is 5 or more before the next shift.
  always_comb begin
    w_adj = r_sh;
    for (int i = 0; i < 3; i++) begin
      if (r_sh[IN_W + 4*i +: 4] >= 4'd5) begin
        w_adj[IN_W + 4*i +: 4] = r_sh[IN_W + 4*i +: 4] + 4'd3;
      end
    end
  end

  assign w_bcd    = r_sh[SH_W-1:IN_W];
  assign w_over   = (32'(r_bin) > MAX_VAL);
  assign w_blank2 = BLANK_LEADING && (w_bcd[11:8] == 4'd0);
  assign w_blank1 = BLANK_LEADING && (w_bcd[11:8] == 4'd0) && (w_bcd[7:4] == 4'd0);

  seg7_encoder u_enc0 (.i_bcd(w_bcd[3:0]),  .i_blank(1'b0),     .o_seg(w_seg0));
  seg7_encoder u_enc1 (.i_bcd(w_bcd[7:4]),  .i_blank(w_blank1), .o_seg(w_seg1));
  seg7_encoder u_enc2 (.i_bcd(w_bcd[11:8]), .i_blank(w_blank2), .o_seg(w_seg2));

  // FSM, double-dabble shift register and pending buffer.
  always_ff @(posedge MAX10_CLK1_50 or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_sh         <= '0;
      r_bin        <= '0;
      r_cnt        <= '0;
      r_pend_valid <= 1'b0;
      r_pend_val   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (value_valid) begin
            // A fresh strobe wins over whatever was pending.
            r_sh         <= SH_W'(value_in);
            r_bin        <= value_in;
            r_cnt        <= '0;
            r_pend_valid <= 1'b0;
            r_state      <= ST_SHIFT;
          end else if (r_pend_valid) begin
            r_sh         <= SH_W'(r_pend_val);
            r_bin        <= r_pend_val;
            r_cnt        <= '0;
            r_pend_valid <= 1'b0;
            r_state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_sh  <= {w_adj[SH_W-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(IN_W - 1)) begin
            r_state <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      // Strobes during a conversion park in the single pending slot.
      if (value_valid && (r_state != ST_IDLE)) begin
        r_pend_val   <= value_in;
        r_pend_valid <= 1'b1;
      end
    end
  end

  // Display registers: load only in UPDATE so the HEX outputs hold otherwise.
  always_ff @(posedge MAX10_CLK1_50 or negedge reset) begin
    if (!reset) begin
      r_hex0 <= SEG_BLANK;
      r_hex1 <= SEG_BLANK;
      r_hex2 <= SEG_BLANK;
      r_ovf  <= 1'b0;
    end else if (r_state == ST_UPDATE) begin
      r_ovf <= w_over;
      if (w_over) begin
        r_hex0 <= SEG_DASH;
        r_hex1 <= SEG_DASH;
        r_hex2 <= SEG_DASH;
      end else begin
        r_hex0 <= w_seg0;
        r_hex1 <= w_seg1;
        r_hex2 <= w_seg2;
      end
    end
  end

  assign HEX0     = r_hex0;
  assign HEX1     = r_hex1;
  assign HEX2     = r_hex2;
  assign overflow = r_ovf;
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_freq_display_driver.sv
// Directed bench for freq_display_driver. Two instances share the clock,
// reset and input strobe: one with leading-zero blanking, one without.
`timescale 1ns/1ps

module tb_freq_display_driver;

  localparam logic [6:0] P_BLANK = 7'b1111111;
  localparam logic [6:0] P_DASH  = 7'b0111111;
  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0010000;

  logic       clk;
  logic       rst_n;
  logic [9:0] value_in;
  logic       value_valid;
  logic [6:0] hex0, hex1, hex2;
  logic       busy, overflow;
  logic [6:0] b_hex0, b_hex1, b_hex2;
  logic       b_busy, b_overflow;

  int n_checks;
  int n_fail;

  freq_display_driver #(.IN_W(10), .MAX_VAL(999), .BLANK_LEADING(1'b1)) dut (
    .MAX10_CLK1_50(clk), .reset(rst_n), .value_in(value_in), .value_valid(value_valid),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .busy(busy), .overflow(overflow)
  );

  freq_display_driver #(.IN_W(10), .MAX_VAL(999), .BLANK_LEADING(1'b0)) dut_nb (
    .MAX10_CLK1_50(clk), .reset(rst_n), .value_in(value_in), .value_valid(value_valid),
    .HEX0(b_hex0), .HEX1(b_hex1), .HEX2(b_hex2), .busy(b_busy), .overflow(b_overflow)
  );

  // Clock: 50 MHz.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_hex(input string tag, input logic [6:0] e2, input logic [6:0] e1,
                           input logic [6:0] e0, input logic eovf);
    check({tag, ".hex2"}, 32'(hex2), 32'(e2));
    check({tag, ".hex1"}, 32'(hex1), 32'(e1));
    check({tag, ".hex0"}, 32'(hex0), 32'(e0));
    check({tag, ".ovf"},  32'(overflow), 32'(eovf));
  endtask

  // One-cycle strobe captured at the next edge (E0).
  task automatic strobe(input logic [9:0] v);
    value_in    = v;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
  endtask

  // Full isolated conversion: strobe at E0, then E1..E11.
  task automatic convert(input logic [9:0] v);
    strobe(v);
    for (int i = 0; i < 11; i++) tick();
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    value_in    = '0;
    value_valid = 1'b0;

    // Reset held for 3 cycles.
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_hex("reset", P_BLANK, P_BLANK, P_BLANK, 1'b0);
    check("reset.busy", 32'(busy), 32'd0);

    // 437: busy across E1..E11, display holds blank until E11.
    strobe(10'd437);
    check("437.busy_e0", 32'(busy), 32'd1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("437.busy_shift", 32'(busy), 32'd1);
    end
    check("437.hold_hex0", 32'(hex0), 32'(P_BLANK));
    tick();
    check_hex("437", P4, P3, P7, 1'b0);
    check("437.busy_done", 32'(busy), 32'd0);

    // 5: leading zeros blanked on one instance, shown on the other.
    convert(10'd5);
    check_hex("5", P_BLANK, P_BLANK, P5, 1'b0);
    check("5nb.hex2", 32'(b_hex2), 32'(P0));
    check("5nb.hex1", 32'(b_hex1), 32'(P0));
    check("5nb.hex0", 32'(b_hex0), 32'(P5));

    convert(10'd0);
    check_hex("0", P_BLANK, P_BLANK, P0, 1'b0);

    // Over-range then the top in-range value.
    convert(10'd1000);
    check_hex("1000", P_DASH, P_DASH, P_DASH, 1'b1);
    check("1000nb.ovf", 32'(b_overflow), 32'd1);
    convert(10'd999);
    check_hex("999", P9, P9, P9, 1'b0);

    // Reset at E5 of a conversion with a pending entry; display shows dashes first.
    convert(10'd1023);
    check_hex("1023", P_DASH, P_DASH, P_DASH, 1'b1);
    strobe(10'd321);
    tick();
    value_in = 10'd654; value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check_hex("midrst", P_BLANK, P_BLANK, P_BLANK, 1'b0);
    check("midrst.busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("midrst.pend_lost_busy", 32'(busy), 32'd0);
    check_hex("midrst.pend_lost", P_BLANK, P_BLANK, P_BLANK, 1'b0);

    // Back-to-back: 123 @E0, 456 @E3, 789 @E5.
    strobe(10'd123);                 // E0
    tick(); tick();                  // E1, E2
    value_in = 10'd456; value_valid = 1'b1;
    tick();                          // E3
    value_valid = 1'b0;
    tick();                          // E4
    value_in = 10'd789; value_valid = 1'b1;
    tick();                          // E5
    value_valid = 1'b0;
    for (int i = 6; i <= 11; i++) tick();
    check_hex("b2b.123", P1, P2, P3, 1'b0);
    check("b2b.busy_e11", 32'(busy), 32'd0);
    tick();                          // E12 loads pending 789
    check("b2b.busy_e12", 32'(busy), 32'd1);
    for (int i = 13; i <= 22; i++) tick();
    check("b2b.hold_e22", 32'(hex0), 32'(P3));
    tick();                          // E23
    check_hex("b2b.789", P7, P8, P9, 1'b0);
    check("b2b.busy_e23", 32'(busy), 32'd0);

    // Strobe 250 in the cycle IDLE would otherwise load pending 600.
    strobe(10'd111);                 // E0
    tick(); tick();                  // E1, E2
    value_in = 10'd600; value_valid = 1'b1;
    tick();                          // E3
    value_valid = 1'b0;
    for (int i = 4; i <= 11; i++) tick();
    check_hex("race.111", P1, P1, P1, 1'b0);
    strobe(10'd250);                 // E12
    for (int i = 13; i <= 23; i++) tick();
    check_hex("race.250", P2, P5, P0, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    check("race.no600_busy", 32'(busy), 32'd0);
    check_hex("race.no600", P2, P5, P0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_display_driver.md
Name: freq_display_driver

Overview:
- Downstream display stage for the frequency detector.
- Takes the 10-bit measured value (0–999) with a one-cycle valid strobe and converts it to three BCD digits using an iterative shift-add-3 (double-dabble) sequence.
- Drives the three active-low 7-segment displays HEX2 (hundreds), HEX1 (tens) and HEX0 (units).
- Holds one pending update while busy, so the detector never needs to stall.

Parameters:
- IN_W, 10: width of the input value.
- MAX_VAL, 999: largest displayable value; anything above it is over-range.
- BLANK_LEADING, 1: 1 = blank leading zeros on HEX2/HEX1; 0 = always show all digits.

Ports:
- MAX10_CLK1_50  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset.
- value_in  input  IN_W  binary value to display.
- value_valid  input  1  one-cycle strobe; value_in is valid while this is high.
- HEX0  output  7  units digit, active-low, bit order {g,f,e,d,c,b,a}.
- HEX1  output  7  tens digit, same encoding.
- HEX2  output  7  hundreds digit, same encoding.
- busy  output  1  high while a conversion is in flight.
- overflow  output  1  high while the displayed value exceeds MAX_VAL.

Behaviour:
- Clock and reset: one clock, MAX10_CLK1_50. Reset is asynchronous and active-low (`reset`=0 resets).
- Reset values:
  - HEX0/1/2 = 7'b1111111 (blank).
  - busy = 0, overflow = 0.
  - pending buffer empty; FSM in IDLE; shift register and iteration counter cleared.
- Reset mid-conversion: abort immediately, all state returns to reset values, nothing is displayed.
- FSM states:
  - IDLE:
    - If value_valid = 1 at an edge: capture value_in and go to SHIFT (this is edge E0). Also clear pending, so the new value wins over the pending one.
    - Else if pending is valid: capture pending, clear it, go to SHIFT.
  - SHIFT:
    - Each edge: add 3 to every BCD nibble that is ≥5, then shift {bcd, bin} left by one.
    - Runs exactly IN_W edges (E1..E10 at the default width), then goes to UPDATE.
  - UPDATE:
    - One edge (E11): register the HEX outputs and overflow, then return to IDLE.
- Latency and busy:
  - HEX outputs change at edge E0 + IN_W + 1 (E11 at default).
  - busy goes 1 after E0 and returns to 0 after E11.
  - Minimum spacing between accepted updates is IN_W + 2 cycles.
- Pending buffer (one entry):
  - value_valid while not in IDLE (SHIFT or UPDATE) stores value_in into pending and sets pending-valid.
  - A newer strobe overwrites an older pending value. Intermediate values are dropped by design.
- Width rules:
  - BCD register is 12 bits (3 nibbles); the shift register is 12 + IN_W bits.
  - The over-range compare uses the captured binary value: value > MAX_VAL.
- Over-range (evaluated at UPDATE):
  - HEX2/1/0 all show a dash, 7'b0111111 (only segment g lit).
  - overflow = 1.
  - overflow clears on the next in-range UPDATE.
- Leading-zero blanking (BLANK_LEADING = 1):
  - HEX2 is blank if hundreds = 0.
  - HEX1 is blank if hundreds = 0 and tens = 0.
  - HEX0 always shows its digit; value 0 displays "0".
- Digit encoding, active-low {g..a}:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Any BCD nibble > 9 (unreachable) displays blank.
- Display hold: between updates, the HEX outputs hold the last registered value. There are no glitches during SHIFT.

Decomposition:
- Shared package, seg7_pkg:
  - Constants SEG_BLANK, SEG_DASH, and the 10-entry digit table SEG_DIGIT[0:9].
  - FSM state encoding for IDLE, SHIFT and UPDATE.
- Sub-module, seg7_encoder: combinational 4-bit BCD → 7-bit active-low pattern with a blank input. Instantiated three times.
- The FSM, double-dabble datapath, pending buffer and output registers stay in freq_display_driver.

Test Plan:
- Reset held low for 3 cycles, then released:
  - HEX0/1/2 = 1111111, busy = 0, overflow = 0.
  - Asserting reset low at E5 of a conversion returns all outputs to these values, and the pending entry is lost.
- value_in = 437, one-cycle strobe at E0:
  - busy = 1 over E1..E11.
  - At E11: HEX2 = 0011001, HEX1 = 0110000, HEX0 = 1111000, overflow = 0.
- value_in = 5:
  - HEX2 = 1111111, HEX1 = 1111111, HEX0 = 0010010.
  - value_in = 0 gives blank, blank, HEX0 = 1000000.
  - With BLANK_LEADING = 0, value 5 gives 1000000, 1000000, 0010010.
- value_in = 1000, then 999:
  - 1000: all HEX = 0111111, overflow = 1.
  - 999: HEX all = 0010000, overflow = 0.
- Back-to-back strobes: 123 at E0, 456 at E3, 789 at E5:
  - 123 is displayed at E11.
  - 789 is captured at E12 and displayed at E23.
  - 456 is never displayed.
- Strobe 250 arriving in the same cycle that IDLE would load a pending 600:
  - 250 is captured and displayed; the pending 600 is discarded.
